// File: rtl/verifuck_pkg.sv
// Shared definitions for the verifuck UART receive/transmit paths.
package verifuck_pkg;

    localparam int BYTE_W    = 8;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/verifuck_byte_fifo.sv
// Small byte FIFO with wrap-bit pointers; head is read combinationally.
module verifuck_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/verifuck_uart_rx.sv
// 8N1 UART receiver feeding a byte FIFO that serves the CPU stdin handshake.
module verifuck_uart_rx
    import verifuck_pkg::*;
#(
    parameter int UART_RX_BAUD = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_pin,
    output logic [BYTE_W-1:0] stdin,
    output logic              stdin_valid,
    input  logic              stdin_ready,
    output logic              rx_frame_err,
    output logic              rx_overrun
);

    if (UART_RX_BAUD < 2 || UART_RX_BAUD > 65535) begin : g_bad_baud
        $error("verifuck_uart_rx: UART_RX_BAUD must be in 2..65535");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("verifuck_uart_rx: FIFO_DEPTH must be a power of two in 2..256");
    end

    localparam logic [15:0] BAUD_LAST = 16'(UART_RX_BAUD - 1);
    localparam logic [15:0] HALF_LAST = 16'((UART_RX_BAUD / 2) - 1);

    logic              rx_meta;
    logic              rxs;
    logic [1:0]        flush;
    logic              armed;
    rx_state_t         state;
    logic [15:0]       cnt;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shift;
    logic              bit_end;
    logic              stop_sample;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign bit_end     = (cnt == BAUD_LAST);
    assign stop_sample = (state == STOP) && bit_end;
    assign push        = stop_sample & rxs;
    assign pop         = stdin_ready & stdin_valid;
    assign stdin_valid = ~fifo_empty;

    // The synchroniser's reset value is not a real line observation, so arming
    // waits until two genuine samples have flushed through before trusting rxs=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            flush   <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= uart_rx_pin;
            rxs     <= rx_meta;
            flush   <= {flush[0], 1'b1};
            if (flush[1] && rxs) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed && !rxs) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        if (!rxs) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift[bit_idx] <= rxs;
                        cnt            <= '0;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= stop_sample & ~rxs;
            if (push && fifo_full && !pop) begin
                rx_overrun <= 1'b1;
            end
        end
    end

    verifuck_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift),
        .head  (stdin),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_verifuck_uart_rx.sv
// Directed bench for verifuck_uart_rx with an 8-cycle bit period and 4-entry FIFO.
module tb_verifuck_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx_pin;
    logic [7:0] stdin;
    logic       stdin_valid;
    logic       stdin_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;
    int err0       = 0;
    int valid_at   = -1;

    verifuck_uart_rx #(
        .UART_RX_BAUD (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_pin  (uart_rx_pin),
        .stdin        (stdin),
        .stdin_valid  (stdin_valid),
        .stdin_ready  (stdin_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rx_frame_err) err_pulses++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One 80-cycle 8N1 frame; optionally pops during the cycle that ends in the stop sample.
    task automatic applyStimulus(input logic [7:0] d, input logic stop_bit, input logic pop_at_push);
        logic [9:0] frame;
        logic       prev;
        frame    = {stop_bit, d, 1'b0};
        valid_at = -1;
        for (int c = 0; c < 80; c++) begin
            uart_rx_pin = frame[c / 8];
            stdin_ready = pop_at_push && (c == 78);
            prev        = stdin_valid;
            step();
            if (!prev && stdin_valid && valid_at < 0) valid_at = c + 1;
        end
        stdin_ready = 1'b0;
        uart_rx_pin = 1'b1;
    endtask

    initial begin
        logic [9:0] partial;
        rst         = 1'b1;
        uart_rx_pin = 1'b1;
        stdin_ready = 1'b0;
        #12;
        checkOutput("reset_stdin", 32'(stdin), 32'h00);
        checkOutput("reset_valid", 32'(stdin_valid), 32'h0);
        checkOutput("reset_frame_err", 32'(rx_frame_err), 32'h0);
        checkOutput("reset_overrun", 32'(rx_overrun), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        $display("[TB] single byte latency");
        err0 = err_pulses;
        applyStimulus(8'h41, 1'b1, 1'b0);
        checkOutput("latency_0x41", 32'(valid_at), 32'd79);
        checkOutput("valid_0x41", 32'(stdin_valid), 32'h1);
        checkOutput("data_0x41", 32'(stdin), 32'h41);
        checkOutput("no_frame_err_0x41", 32'(err_pulses - err0), 32'd0);
        checkOutput("no_overrun_0x41", 32'(rx_overrun), 32'h0);
        stdin_ready = 1'b1;
        step();
        stdin_ready = 1'b0;
        checkOutput("drained_0x41", 32'(stdin_valid), 32'h0);

        $display("[TB] back-to-back frames");
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        stdin_ready = 1'b1;
        checkOutput("b2b_valid", 32'(stdin_valid), 32'h1);
        checkOutput("b2b_pop0", 32'(stdin), 32'h00);
        step();
        checkOutput("b2b_pop1", 32'(stdin), 32'hFF);
        step();
        checkOutput("b2b_pop2", 32'(stdin), 32'hA5);
        step();
        checkOutput("b2b_empty", 32'(stdin_valid), 32'h0);
        stdin_ready = 1'b0;

        $display("[TB] start glitch");
        err0 = err_pulses;
        uart_rx_pin = 1'b0;
        idle(2);
        uart_rx_pin = 1'b1;
        idle(20);
        checkOutput("glitch_no_push", 32'(stdin_valid), 32'h0);
        checkOutput("glitch_no_err", 32'(err_pulses - err0), 32'd0);
        applyStimulus(8'h96, 1'b1, 1'b0);
        checkOutput("after_glitch_data", 32'(stdin), 32'h96);
        checkOutput("after_glitch_latency", 32'(valid_at), 32'd79);
        stdin_ready = 1'b1;
        step();
        stdin_ready = 1'b0;

        $display("[TB] framing error");
        err0 = err_pulses;
        applyStimulus(8'h55, 1'b0, 1'b0);
        idle(20);
        checkOutput("frame_err_pulses", 32'(err_pulses - err0), 32'd1);
        checkOutput("frame_err_no_push", 32'(stdin_valid), 32'h0);
        checkOutput("frame_err_no_overrun", 32'(rx_overrun), 32'h0);

        $display("[TB] overflow");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b0);
            if (i == 4) checkOutput("ovf_before_5th", 32'(rx_overrun), 32'h0);
        end
        checkOutput("ovf_after_5th", 32'(rx_overrun), 32'h1);
        stdin_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput("ovf_contents", 32'(stdin), 32'(i));
            step();
        end
        checkOutput("ovf_drained", 32'(stdin_valid), 32'h0);
        stdin_ready = 1'b0;
        checkOutput("ovf_sticky", 32'(rx_overrun), 32'h1);

        $display("[TB] pop in the fifth push cycle");
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(10);
        checkOutput("overrun_cleared", 32'(rx_overrun), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, i == 5);
        end
        checkOutput("simul_no_overrun", 32'(rx_overrun), 32'h0);
        stdin_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            checkOutput("simul_contents", 32'(stdin), 32'(i));
            step();
        end
        checkOutput("simul_drained", 32'(stdin_valid), 32'h0);
        stdin_ready = 1'b0;

        $display("[TB] reset mid-frame");
        partial = {1'b1, 8'h3C, 1'b0};
        for (int c = 0; c < 36; c++) begin
            uart_rx_pin = partial[c / 8];
            step();
        end
        rst         = 1'b1;
        uart_rx_pin = 1'b0;
        idle(2);
        rst  = 1'b0;
        err0 = err_pulses;
        idle(30);
        checkOutput("rst_low_no_push", 32'(stdin_valid), 32'h0);
        checkOutput("rst_low_no_err", 32'(err_pulses - err0), 32'd0);
        uart_rx_pin = 1'b1;
        idle(20);
        checkOutput("rst_high_no_push", 32'(stdin_valid), 32'h0);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        checkOutput("rst_clean_latency", 32'(valid_at), 32'd79);
        checkOutput("rst_clean_data", 32'(stdin), 32'h3C);
        stdin_ready = 1'b1;
        step();
        stdin_ready = 1'b0;
        checkOutput("rst_clean_drained", 32'(stdin_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
